// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin arbiter sharing one two-stage pipelined adder
// Optional build: define ADDER_SHARE_SAT_EN to saturate res_sum instead of returning the carry.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH:0]        res_sum,
  output logic [1:0]            inflight
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic             op_valid;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   ptr;

  logic             adv0;
  logic             adv1;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     scan;
  logic             xfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH:0]   sum_next;

  assign adv1 = ~res_valid | res_ready;
  assign adv0 = ~op_valid | adv1;

  // Scan from ptr upward, wrapping modulo NREQ; first asserted valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!grant_found && req_valid[scan[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && adv0 && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer  = |req_ready;
  assign sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
`ifdef ADDER_SHARE_SAT_EN
  assign sum_next = sum_full[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : sum_full;
`else
  assign sum_next = sum_full;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_valid <= 1'b0;
      op_id    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      ptr      <= '0;
    end else begin
      if (adv0) begin
        op_valid <= xfer;
        if (xfer) begin
          op_id <= grant_idx;
          op_a  <= sel_a;
          op_b  <= sel_b;
        end
      end
      if (xfer) ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
    end else if (adv1) begin
      res_valid <= op_valid;
      res_id    <= op_id;
      res_sum   <= sum_next;
    end
  end

  assign inflight = {1'b0, op_valid} + {1'b0, res_valid};

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard bench for adder_share_arb with a queue-based reference model
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int MAXV = (1 << W) - 1;
`ifdef ADDER_SHARE_SAT_EN
  localparam int EXP_CARRY = 'h0FF;
`else
  localparam int EXP_CARRY = 'h110;
`endif

  typedef struct {
    int id;
    int sum;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   v;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] av;
  logic [NREQ*W-1:0] bv;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [W:0]        res_sum;
  logic [1:0]        inflight;

  exp_t sb[$];
  int   grants[$];
  int   ptr_m;
  int   mode;
  int   errors = 0;
  int   checks = 0;
  exp_t e_m;
  int   snap_sum;
  int   snap_id;

  adder_share_arb #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(v), .req_ready(req_ready), .req_a(av), .req_b(bv),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef ADDER_SHARE_SAT_EN
    if (s > MAXV) s = MAXV;
`endif
    return s;
  endfunction

  task automatic set_req(input int i, input int a, input int b);
    v[i] = 1'b1;
    av[i*W +: W] = W'(a);
    bv[i*W +: W] = W'(b);
  endtask

  // One cycle: predict the grant from the arbitration rules, push the expected result, then update requesters.
  task automatic step();
    int g;
    int idx;
    logic [NREQ-1:0] er;
    bit allowed;
    @(negedge clk);
    chk("inflight", int'(inflight), sb.size());
    allowed = (sb.size() < 2) || res_ready;
    g = -1;
    if (allowed)
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", int'(req_ready), int'(er));
    if (g >= 0) begin
      e_m.id  = g;
      e_m.sum = exp_sum(int'(av[g*W +: W]), int'(bv[g*W +: W]));
      sb.push_back(e_m);
      grants.push_back(g);
      ptr_m = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (mode == 0) v[g] = 1'b0;
      else if (mode == 1 || $urandom_range(0, 1) == 1)
        set_req(g, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
      else v[g] = 1'b0;
    end
    if (mode == 2) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++)
        if (!v[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    v = '1;
    @(negedge clk);
    chk("rst req_ready", int'(req_ready), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk("rst res_id", int'(res_id), 0);
    chk("rst res_sum", int'(res_sum), 0);
    chk("rst inflight", int'(inflight), 0);
    sb.delete();
    grants.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    v = '0;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    mode = 0;
    v = '0;
    res_ready = 1'b1;
    repeat (4) step();
    chk("drain empty", sb.size(), 0);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (reset_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got id=%0d sum=%0h expected no result", res_id, res_sum);
      end else begin
        e_m = sb.pop_front();
        chk("res_id", int'(res_id), e_m.id);
        chk("res_sum", int'(res_sum), e_m.sum);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    v = '0;
    av = '0;
    bv = '0;
    res_ready = 1'b1;
    mode = 0;
    ptr_m = 0;

    // single request and latency
    do_reset();
    set_req(2, 'h12, 'h34);
    step();
    @(negedge clk);
    chk("lat1 res_valid", int'(res_valid), 0);
    chk("lat1 inflight", int'(inflight), 1);
    @(negedge clk);
    chk("lat2 res_valid", int'(res_valid), 1);
    chk("lat2 res_id", int'(res_id), 2);
    chk("lat2 res_sum", int'(res_sum), 'h046);
    drain();

    // round robin with all requesters held high
    do_reset();
    mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    repeat (6) step();
    chk("rr count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) chk("rr order", grants[i], i % NREQ);
    drain();

    // backpressure: two accepts then stall with stable outputs
    do_reset();
    mode = 1;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    repeat (3) step();
    @(negedge clk);
    chk("bp inflight", int'(inflight), 2);
    snap_sum = int'(res_sum);
    snap_id  = int'(res_id);
    repeat (3) step();
    chk("bp accepts", grants.size(), 2);
    @(negedge clk);
    chk("bp req_ready", int'(req_ready), 0);
    chk("bp res_sum stable", int'(res_sum), snap_sum);
    chk("bp res_id stable", int'(res_id), snap_id);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    repeat (4) step();
    chk("bp resume accepts", grants.size(), 6);
    drain();

    // carry or saturation
    do_reset();
    set_req(0, 'hF0, 'h20);
    step();
    @(negedge clk);
    @(negedge clk);
    chk("carry res_valid", int'(res_valid), 1);
    chk("carry res_sum", int'(res_sum), EXP_CARRY);
    drain();

    // reset while two operations are in flight
    do_reset();
    mode = 1;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
    repeat (3) step();
    @(negedge clk);
    chk("mid inflight", int'(inflight), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid rst res_valid", int'(res_valid), 0);
    chk("mid rst req_ready", int'(req_ready), 0);
    chk("mid rst inflight", int'(inflight), 0);
    sb.delete();
    grants.delete();
    ptr_m = 0;
    v = '0;
    set_req(1, 'h05, 'h07);
    set_req(3, 'h80, 'h80);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mode = 0;
    repeat (2) step();
    chk("mid grant count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("mid first grant", grants[0], 1);
      chk("mid second grant", grants[1], 3);
    end
    drain();

    // pointer wrap
    do_reset();
    set_req(3, 'h01, 'h02);
    step();
    set_req(0, 'h03, 'h04);
    set_req(3, 'h05, 'h06);
    repeat (2) step();
    chk("wrap count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("wrap g0", grants[0], 3);
      chk("wrap g1", grants[1], 0);
      chk("wrap g2", grants[2], 3);
    end
    drain();

    // randomized traffic with random backpressure
    do_reset();
    mode = 2;
    repeat (400) step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
